// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Waits for a stable PLL lock, then releases N active-low reset
//               domains in order with a fixed spacing between releases.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
   parameter int N         = 4,
   parameter int STAGE_DLY = 16,
   parameter int LOCK_CYC  = 32,
   parameter int TIMEOUT   = 65536
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         enable,
   input  logic         pll_locked,
   input  logic         sw_rst,
   output logic [N-1:0] rstno,
   output logic         ready,
   output logic         fault,
   output logic [2:0]   state
);

   localparam int c_LW = $clog2(LOCK_CYC) + 1;
   localparam int c_TW = $clog2(TIMEOUT) + 1;
   localparam int c_SW = $clog2(STAGE_DLY) + 1;
   localparam int c_IW = $clog2(N) + 1;

   localparam logic [c_LW-1:0] c_LOCK_LAST = c_LW'(LOCK_CYC - 1);
   localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT - 1);
   localparam logic [c_SW-1:0] c_STG_LAST  = c_SW'(STAGE_DLY - 1);
   localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(N - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   state_t          r_state,    w_state_nx;
   logic [c_LW-1:0] r_lock_cnt, w_lock_nx;
   logic [c_TW-1:0] r_to_cnt,   w_to_nx;
   logic [c_SW-1:0] r_stg_cnt,  w_stg_nx;
   logic [c_IW-1:0] r_idx,      w_idx_nx;
   logic [N-1:0]    r_rstno,    w_rstno_nx;
   logic            r_ready,    w_ready_nx;
   logic            r_fault,    w_fault_nx;
   logic            w_clr;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_lock_cnt <= '0;
         r_to_cnt   <= '0;
         r_stg_cnt  <= '0;
         r_idx      <= '0;
         r_rstno    <= '0;
         r_ready    <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_lock_cnt <= w_lock_nx;
         r_to_cnt   <= w_to_nx;
         r_stg_cnt  <= w_stg_nx;
         r_idx      <= w_idx_nx;
         r_rstno    <= w_rstno_nx;
         r_ready    <= w_ready_nx;
         r_fault    <= w_fault_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_lock_nx  = r_lock_cnt;
      w_to_nx    = r_to_cnt;
      w_stg_nx   = r_stg_cnt;
      w_idx_nx   = r_idx;
      w_rstno_nx = r_rstno;
      w_clr      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nx = ST_WAIT;
               w_clr      = 1'b1;
            end
         end
         ST_WAIT: begin
            if (!enable) begin
               w_state_nx = ST_IDLE;
               w_clr      = 1'b1;
            end else if (sw_rst) begin
               w_state_nx = ST_WAIT;
               w_clr      = 1'b1;
            end else if (pll_locked && (r_lock_cnt == c_LOCK_LAST)) begin
               w_state_nx = ST_RELEASE;
               w_clr      = 1'b1;
            end else if (r_to_cnt == c_TO_LAST) begin
               w_state_nx = ST_FAULT;
               w_clr      = 1'b1;
            end else begin
               // A lock dropout restarts the stability window but not the timeout
               w_lock_nx = pll_locked ? r_lock_cnt + 1'b1 : '0;
               w_to_nx   = r_to_cnt + 1'b1;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (!enable) begin
               w_state_nx = ST_IDLE;
               w_clr      = 1'b1;
            end else if (sw_rst || !pll_locked) begin
               w_state_nx = ST_WAIT;
               w_clr      = 1'b1;
            end else if (r_state == ST_RELEASE) begin
               if (r_stg_cnt == c_STG_LAST) begin
                  w_stg_nx = '0;
                  w_idx_nx = r_idx + 1'b1;
                  for (int i = 0; i < N; i++) begin
                     if (r_idx == c_IW'(i)) w_rstno_nx[i] = 1'b1;
                  end
                  if (r_idx == c_IDX_LAST) begin
                     w_state_nx = ST_RUN;
                     w_clr      = 1'b1;
                  end
               end else begin
                  w_stg_nx = r_stg_cnt + 1'b1;
               end
            end
         end
         ST_FAULT: begin
            if (!enable) begin
               w_state_nx = ST_IDLE;
               w_clr      = 1'b1;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_clr      = 1'b1;
         end
      endcase

      if (w_clr) begin
         w_lock_nx = '0;
         w_to_nx   = '0;
         w_stg_nx  = '0;
         w_idx_nx  = '0;
      end

      // All domains drop together on any exit from the release path
      if ((w_state_nx != ST_RELEASE) && (w_state_nx != ST_RUN)) w_rstno_nx = '0;
      if (w_state_nx == ST_RUN) w_rstno_nx = '1;

      w_ready_nx = (w_state_nx == ST_RUN);
      w_fault_nx = (w_state_nx == ST_FAULT);
   end

   assign rstno = r_rstno;
   assign ready = r_ready;
   assign fault = r_fault;
   assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_sequencer
// Description : Randomised and directed bench for rst_sequencer against a
//               behavioural model. Revision 1.0
// ============================================================================
module tb_rst_sequencer;

   localparam int TN  = 3;
   localparam int TSD = 4;
   localparam int TLC = 8;
   localparam int TTO = 100;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          enable = 1'b0;
   logic          pll_locked = 1'b0;
   logic          sw_rst = 1'b0;
   logic [TN-1:0] rstno;
   logic          ready;
   logic          fault;
   logic [2:0]    state;

   int n_vec = 0;
   int n_err = 0;

   // model: state code, consecutive-lock run, cycles waited, cycles in stage, domains released
   int m_st = 0, m_lock = 0, m_wait = 0, m_stg = 0, m_rel = 0;
   bit m_valid = 0;

   rst_sequencer #(.N(TN), .STAGE_DLY(TSD), .LOCK_CYC(TLC), .TIMEOUT(TTO)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .pll_locked(pll_locked),
      .sw_rst(sw_rst), .rstno(rstno), .ready(ready), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic m_goto(input int s);
      m_st = s; m_lock = 0; m_wait = 0; m_stg = 0; m_rel = 0;
   endtask

   task automatic model_step();
      bit lock_ok, timed;
      if (!rstn) begin
         m_goto(0);
         m_valid = 1;
      end else begin
         case (m_st)
            0: if (enable) m_goto(1);
            1: begin
               if (!enable)      m_goto(0);
               else if (sw_rst)  m_goto(1);
               else begin
                  lock_ok = pll_locked && (m_lock + 1 == TLC);
                  timed   = (m_wait + 1 == TTO);
                  m_lock  = pll_locked ? m_lock + 1 : 0;
                  m_wait++;
                  if (lock_ok)    m_goto(2);
                  else if (timed) m_goto(4);
               end
            end
            2, 3: begin
               if (!enable)                    m_goto(0);
               else if (sw_rst || !pll_locked) m_goto(1);
               else if (m_st == 2) begin
                  m_stg++;
                  if (m_stg == TSD) begin
                     m_stg = 0;
                     m_rel++;
                     if (m_rel == TN) m_goto(3);
                  end
               end
            end
            4: if (!enable) m_goto(0);
            default: m_goto(0);
         endcase
      end
   endtask

   function automatic int exp_rstno();
      if (m_st == 3) return (1 << TN) - 1;
      if (m_st == 2) return (1 << m_rel) - 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         check("rstno", int'(rstno), exp_rstno());
         check("ready", int'(ready), int'(m_st == 3));
         check("fault", int'(fault), int'(m_st == 4));
         check("state", int'(state), m_st);
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic do_reset();
      rstn = 1'b0; enable = 1'b0; pll_locked = 1'b0; sw_rst = 1'b0;
      ticks(2);
      rstn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected end before 2ms");
      $fatal(1);
   end

   initial begin
      // Nominal ordered release
      do_reset();
      check("lit_reset_state", int'(state), 0);
      check("lit_reset_rstno", int'(rstno), 0);
      enable = 1'b1; pll_locked = 1'b1;
      tick();                                   // E0
      ticks(11);
      check("lit_e11_rstno", int'(rstno), 0);
      tick();
      check("lit_e12_rstno", int'(rstno), 3'b001);
      ticks(4);
      check("lit_e16_rstno", int'(rstno), 3'b011);
      ticks(4);
      check("lit_e20_rstno", int'(rstno), 3'b111);
      check("lit_e20_ready", int'(ready), 1);
      check("lit_e20_state", int'(state), 3);

      // Lock loss in RUN
      ticks(3);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      check("lit_lockloss_rstno", int'(rstno), 0);
      check("lit_lockloss_ready", int'(ready), 0);
      check("lit_lockloss_state", int'(state), 1);
      ticks(11);
      check("lit_relock_pre", int'(rstno), 0);
      tick();
      check("lit_relock_bit0", int'(rstno), 3'b001);

      // Lock timeout and FAULT exit
      do_reset();
      enable = 1'b1; pll_locked = 1'b0;
      tick();                                   // E0
      ticks(99);
      check("lit_e99_state", int'(state), 1);
      tick();
      check("lit_e100_fault", int'(fault), 1);
      check("lit_e100_state", int'(state), 4);
      check("lit_e100_rstno", int'(rstno), 0);
      pll_locked = 1'b1; sw_rst = 1'b1;
      ticks(5);
      sw_rst = 1'b0;
      check("lit_fault_hold", int'(state), 4);
      enable = 1'b0;
      tick();
      check("lit_fault_exit_state", int'(state), 0);
      check("lit_fault_exit_fault", int'(fault), 0);

      // One-cycle lock glitch in WAIT_LOCK
      do_reset();
      enable = 1'b1; pll_locked = 1'b1;
      tick();                                   // E0
      ticks(5);
      pll_locked = 1'b0;
      tick();                                   // E6 samples the dropout
      pll_locked = 1'b1;
      ticks(11);
      check("lit_glitch_e17", int'(rstno), 0);
      tick();
      check("lit_glitch_e18", int'(rstno), 3'b001);

      // Software re-sequence mid-release, then sw_rst ignored in IDLE
      do_reset();
      enable = 1'b1; pll_locked = 1'b1;
      tick();                                   // E0
      ticks(14);
      check("lit_e14_rstno", int'(rstno), 3'b001);
      sw_rst = 1'b1;
      tick();
      sw_rst = 1'b0;
      check("lit_swrst_rstno", int'(rstno), 0);
      check("lit_swrst_state", int'(state), 1);
      ticks(12);
      check("lit_swrst_rerun", int'(rstno), 3'b001);
      enable = 1'b0;
      tick();
      sw_rst = 1'b1;
      tick();
      sw_rst = 1'b0;
      check("lit_idle_swrst", int'(state), 0);

      // rstn pulse mid-release
      enable = 1'b1;
      tick();                                   // E0
      ticks(16);
      check("lit_rel_rstno", int'(rstno), 3'b011);
      rstn = 1'b0;
      tick();
      check("lit_rstn_state", int'(state), 0);
      check("lit_rstn_rstno", int'(rstno), 0);
      check("lit_rstn_ready", int'(ready), 0);
      rstn = 1'b1;
      tick();
      check("lit_rstn_resume", int'(state), 1);

      // Randomised traffic with phases of good, absent and flaky lock
      begin
         int mode;
         mode = 0;
         for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
               0:       pll_locked = ($urandom_range(0, 99) < 98);
               1:       pll_locked = ($urandom_range(0, 99) < 1);
               default: pll_locked = ($urandom_range(0, 1) == 1);
            endcase
            enable = ($urandom_range(0, 149) != 0);
            sw_rst = ($urandom_range(0, 79) == 0);
            rstn   = ($urandom_range(0, 499) != 0);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rst_sequencer.md
# rst_sequencer

Ordered reset-release controller for the design's filtered reset tree. It waits for a stable clock-source lock, then releases N active-low reset domains one at a time, with a fixed spacing between releases. It re-asserts every domain on lock loss, software request or disable, and flags a fault if lock never arrives. It sits downstream of the board reset filter: that filter's output drives this block's `rstn`, and each `rstno` bit feeds one domain's local reset filter.

## Interface
- `N`, default 4: number of reset domains, ≥1. Domain 0 is released first.
- `STAGE_DLY`, default 16: cycles between consecutive domain releases, ≥1.
- `LOCK_CYC`, default 32: consecutive cycles `pll_locked` must be high to count as stable, ≥1.
- `TIMEOUT`, default 65536: maximum cycles spent in WAIT_LOCK before FAULT, greater than `LOCK_CYC`.

- `clk`, input, 1: single clock. All logic is on its rising edge.
- `rstn`, input, 1: reset, synchronous, active-low.
- `enable`, input, 1: level. Low forces IDLE.
- `pll_locked`, input, 1: clock-source lock. Already synchronous to `clk`.
- `sw_rst`, input, 1: one-cycle request to re-run the sequence.
- `rstno`, output, N: per-domain reset, active-low. Bit i is 1 when domain i is released.
- `ready`, output, 1: high only in RUN.
- `fault`, output, 1: high only in FAULT.
- `state`, output, 3: encoded state for debug. IDLE=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.

## Operation
- All outputs are registered.
- While `rstn`=0 at an edge: state=IDLE, `rstno`='0, `ready`=0, `fault`=0, and all counters and the stage index are 0.
- IDLE:
  - `rstno`='0.
  - `enable`=1 → WAIT_LOCK. Lock counter and timeout counter are cleared.
- WAIT_LOCK:
  - `rstno`='0.
  - Each edge with `pll_locked`=1 increments the lock counter; an edge with `pll_locked`=0 clears it.
  - An edge where `pll_locked`=1 and lock counter = `LOCK_CYC`-1 → RELEASE, with stage index 0 and stage counter 0.
  - The timeout counter increments every edge. An edge where it equals `TIMEOUT`-1 and the lock exit is not taken → FAULT.
- RELEASE:
  - The stage counter increments each edge.
  - An edge where it equals `STAGE_DLY`-1 sets `rstno[idx]`=1, clears the counter and increments idx.
  - When idx=N-1 is released, the state becomes RUN on that same edge.
  - Released bits stay 1.
- RUN: `rstno`='1, `ready`=1.
- FAULT:
  - `rstno`='0, `fault`=1.
  - The block leaves FAULT only through `enable`=0 (→ IDLE) or `rstn`.
  - `pll_locked` and `sw_rst` are ignored.
- Abort rules, checked in priority order at every edge in WAIT_LOCK, RELEASE and RUN:
  1. `enable`=0 → IDLE.
  2. `sw_rst`=1 → WAIT_LOCK.
  3. `pll_locked`=0 while in RELEASE or RUN → WAIT_LOCK.
- Every abort clears `rstno` to '0 and clears `ready` on the same edge, and clears all counters and idx.
- `sw_rst` in IDLE is ignored.
- Counter widths are $clog2 of the respective parameter, +1. No wrap-around: each counter is cleared on every state transition.

## Timing
- Let E0 be the edge at which IDLE samples `enable`=1. With `pll_locked`=1 continuously:
  - RELEASE is entered at E`LOCK_CYC`.
  - `rstno[i]` rises at E(`LOCK_CYC`+(i+1)·`STAGE_DLY`).
  - `ready` rises on the same edge as `rstno[N-1]`.
- Reset assertion latency from an abort condition is exactly 1 edge. All `rstno` bits fall together, never staged.
- A `pll_locked` glitch of one cycle in WAIT_LOCK restarts the `LOCK_CYC` count. It does not restart the timeout count.
- Without lock, FAULT is entered at E`TIMEOUT`, counting from entry into WAIT_LOCK at E0.
- `sw_rst` and `pll_locked`=0 on the same edge: WAIT_LOCK. Both rules lead to the same result.
- `rstn` low mid-sequence overrides everything, including FAULT.

## Test plan
1. Use N=3, STAGE_DLY=4, LOCK_CYC=8, TIMEOUT=100. After reset, `enable`=1 at E0 and `pll_locked`=1 constant → `rstno` goes 001 at E12, 011 at E16, 111 at E20. `ready`=1 from E20 and `state`=3.
2. Same config, in RUN, drop `pll_locked` for 1 cycle → `rstno`=000 and `ready`=0 on the next edge, `state`=1. After the lock returns, the full sequence reruns with `rstno[0]` released 12 edges after the re-lock edge.
3. `pll_locked`=0 throughout → `fault`=1 and `state`=4 at E100 with `rstno`=000. Raising `pll_locked` keeps FAULT. Setting `enable`=0 gives IDLE on the next edge and `fault`=0.
4. `pll_locked` toggles low for 1 cycle at E5 → `rstno[0]` is delayed to E18. This is a regression check that the lock counter restarts and the timeout counter does not.
5. `sw_rst` pulse at E14, between the releases of bits 0 and 1 → `rstno`=000 at E15, then re-sequencing from WAIT_LOCK. `sw_rst` pulsed in IDLE → no state change.
6. `rstn`=0 for 1 edge while in RELEASE with `rstno`=011 → all outputs are at reset values on that edge. With `enable` held high, `state`=1 one edge after `rstn` returns high.
